// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | pc_fetch_unit : fetch PC sequencer with imem ready handshake and redirects.
// | Optional PC_ALIGN_CHECK_EN: forces redirect targets word-aligned, adds misalign.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int              n        = 16,
  parameter logic [n-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         imem_ready,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_pc4,
  input  logic [n-1:0] branch_off_sl2,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic         jr,
  input  logic [n-1:0] jr_target,
  output logic [n-1:0] pc,
  output logic         imem_req,
  output logic [n-1:0] fetch_pc,
  output logic         fetch_valid,
`ifdef PC_ALIGN_CHECK_EN
  output logic         misalign,
`endif
  output logic         flush
);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_fetch    = 2'd1;
  localparam logic [1:0] c_wait     = 2'd2;
  localparam logic [1:0] c_redirect = 2'd3;
  localparam logic [n-1:0] c_four   = n'(4);

  logic [1:0]   r_state;
  logic [n-1:0] r_pc;
  logic [n-1:0] r_fetch_pc;
  logic         r_fetch_valid;
  logic         r_flush;
  logic         r_misalign;

  logic         w_redirect;
  logic [n-1:0] w_target_raw;
  logic [n-1:0] w_target;
  logic         w_misalign;
  logic         w_busy;

  assign w_redirect = jr | jump | branch_taken;
  assign w_busy     = (r_state == c_fetch) || (r_state == c_wait);

  // jr beats jump beats branch
  always_comb begin
    w_target_raw = branch_pc4 + branch_off_sl2;
    if (jr)
      w_target_raw = jr_target;
    else if (jump)
      w_target_raw = jump_target;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign w_target   = {w_target_raw[n-1:2], 2'b00};
  assign w_misalign = |w_target_raw[1:0];
  assign misalign   = r_misalign;
`else
  assign w_target   = w_target_raw;
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_idle;
      r_pc          <= RESET_PC;
      r_fetch_pc    <= '0;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_misalign    <= 1'b0;
    end else if (!stall) begin
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_misalign    <= 1'b0;
      if (r_state == c_idle) begin
        r_state <= c_fetch;
      end else if (w_redirect) begin
        // any in-flight completion this cycle is dropped
        r_pc       <= w_target;
        r_flush    <= 1'b1;
        r_misalign <= w_misalign;
        r_state    <= c_redirect;
      end else if (r_state == c_redirect) begin
        r_state <= c_fetch;
      end else if (imem_ready) begin
        r_fetch_pc    <= r_pc;
        r_pc          <= r_pc + c_four;
        r_fetch_valid <= 1'b1;
        r_state       <= c_fetch;
      end else begin
        r_state <= c_wait;
      end
    end
  end

  assign pc          = r_pc;
  assign imem_req    = w_busy & ~stall;
  assign fetch_pc    = r_fetch_pc;
  assign fetch_valid = r_fetch_valid;
  assign flush       = r_flush;

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer for the 16-bit core.
- Holds the fetch PC and issues fetch requests to instruction memory with a ready handshake.
- Selects the next PC from sequential, branch, jump or register-jump sources.
- Sits directly downstream of the shift-left-two stage: it consumes the word-aligned branch offset and jump target that stage produces, and adds the branch offset to the branch's PC+4.

Parameters:
n, 16, datapath/address width in bits
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  freeze all state, PC and registered outputs; forces imem_req low
imem_ready  input  1  instruction memory accepts/completes current request this cycle
branch_taken  input  1  resolved taken branch
branch_pc4  input  n  PC+4 of the branch instruction
branch_off_sl2  input  n  sign-extended offset already shifted left two
jump  input  1  absolute jump
jump_target  input  n  absolute jump address, already shifted left two
jr  input  1  register jump
jr_target  input  n  register jump address
pc  output  n  current fetch address
imem_req  output  1  fetch request to instruction memory
fetch_pc  output  n  address of the most recently completed fetch
fetch_valid  output  1  one-cycle pulse: a fetch at fetch_pc has completed
flush  output  1  one-cycle pulse: younger in-flight instructions must be discarded

Behaviour:
- The design uses one clock and one reset: reset is synchronous and active-high, on clk.
- Reset values:
  - pc = RESET_PC; fetch_pc = 0
  - fetch_valid = 0, flush = 0
  - state = IDLE, so imem_req = 0
- Reset mid-wait abandons the request. No fetch_valid is produced for it.
- States:
  - IDLE: after reset; moves unconditionally to FETCH next cycle, unless stall is high.
  - FETCH: first cycle of a request.
  - WAIT: request outstanding.
  - REDIRECT: one bubble cycle after a redirect.
- imem_req = 1 in FETCH and WAIT, 0 in IDLE and REDIRECT. It is decoded combinationally from state and stall, so stall forces it low.
- Arithmetic wraps modulo 2^n:
  - pc+4 for sequential fetch
  - branch target = branch_pc4 + branch_off_sl2
- redirect = jr | jump | branch_taken. Priority is jr > jump > branch_taken.
  - The selected target loads into pc at the edge.
- Redirect has priority over completion in every non-IDLE state when stall is low:
  - flush <= 1 for exactly one cycle.
  - State goes to REDIRECT.
  - fetch_valid <= 0, even if imem_ready is high that same cycle; that fetch is discarded.
- Redirect in REDIRECT state is accepted: new target is loaded, flush pulses again, state stays in REDIRECT.
- Redirect in IDLE is ignored.
- Completion = (FETCH or WAIT) & imem_ready & !redirect & !stall:
  - fetch_pc <= pc
  - pc <= pc+4
  - fetch_valid <= 1
  - state <= FETCH, giving back-to-back fetches at one per cycle when ready stays high.
- FETCH or WAIT without imem_ready (and no redirect): state <= WAIT; pc held; fetch_valid <= 0.
- REDIRECT with no new redirect: state goes to FETCH next cycle.
- stall high: state, pc, fetch_pc, fetch_valid and flush hold their values.
  - Redirect inputs are ignored; the pipeline must hold them until stall drops.
- Wrap-around: pc = 16'hFFFC completes and pc becomes 16'h0000, no error.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Add output misalign (1 bit, reset 0).
  - A selected redirect target with bits [1:0] != 0 loads pc with bits [1:0] forced to 00.
  - misalign pulses 1 for one cycle alongside flush.
- When undefined:
  - No misalign port.
  - Targets are loaded unmodified, with no check.

Test Plan:
- Reset then imem_ready held 1 -> IDLE one cycle, then fetch_valid pulses every cycle with fetch_pc = 0000, 0004, 0008; flush stays 0.
- imem_ready low 3 cycles at pc=0008 -> state WAIT, imem_req 1, pc holds 0008; on ready, fetch_pc=0008 and pc=000C.
- branch_taken with branch_pc4=0010 and branch_off_sl2=FFF8 -> pc=0008, flush pulses one cycle, one cycle with imem_req 0, then fetch resumes at 0008.
- jr=1 (jr_target=0100), jump=1 (jump_target=0200) and imem_ready=1 in the same cycle -> pc=0100, no fetch_valid that cycle, flush=1.
- stall held 2 cycles during WAIT with a branch asserted -> pc, state and outputs unchanged, imem_req 0; after release the branch is taken; pc=FFFC completing -> pc=0000.
- PC_ALIGN_CHECK_EN defined, jr_target=0103 -> pc=0100, misalign and flush pulse together; undefined -> pc=0103.
